// File: rtl/leaf_out_arbiter.sv
// leaf_out_arbiter: round-robin, credit-gated merge of user output streams into one BFT packet register
module leaf_out_arbiter #(
  parameter int NUM_OUT_PORTS = 4,
  parameter int PAYLOAD_BITS = 32,
  parameter int PACKET_BITS = 49,
  parameter int NUM_LEAF_BITS = 5,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_ADDR_BITS = 7,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                                    clk_400,
  input  logic                                    reset_400,
  input  logic                                    ap_start,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   din_leaf_user2interface,
  input  logic [NUM_OUT_PORTS-1:0]                vld_user2interface,
  output logic [NUM_OUT_PORTS-1:0]                ack_interface2user,
  input  logic                                    cfg_we,
  input  logic [1:0]                              cfg_port,
  input  logic [NUM_LEAF_BITS-1:0]                cfg_leaf,
  input  logic [NUM_PORT_BITS-1:0]                cfg_dport,
  input  logic                                    credit_upd,
  input  logic [1:0]                              credit_port,
  output logic [PACKET_BITS-1:0]                  dout_leaf_interface2bft,
  input  logic                                    bft_ready
);
  localparam int PW = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
  localparam int CW = NUM_ADDR_BITS + 1;
  localparam int CMAX = 1 << NUM_ADDR_BITS;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0] state, state_nxt;
  logic [PW-1:0] rr, gnt;
  logic [CW-1:0] credit [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] addr [NUM_OUT_PORTS];
  logic [NUM_LEAF_BITS-1:0] dst_leaf [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0] dst_port [NUM_OUT_PORTS];
  logic [NUM_OUT_PORTS-1:0] elig;
  int sum [NUM_OUT_PORTS];
  logic out_vld, grant;
  logic [PACKET_BITS-1:0] out_pkt;

  always_comb begin
    for (int i = 0; i < NUM_OUT_PORTS; i++)
      elig[i] = vld_user2interface[i] && (credit[i] != '0);
  end

  // Scan from the highest offset down so the port nearest rr wins.
  always_comb begin
    gnt = '0;
    for (int k = NUM_OUT_PORTS - 1; k >= 0; k--)
      if (elig[(int'(rr) + k) % NUM_OUT_PORTS]) gnt = PW'((int'(rr) + k) % NUM_OUT_PORTS);
  end

  // Reset gates the grant so no word is acked while a pending packet is being discarded.
  assign grant = !reset_400 && (state == RUN) && (!out_vld || bft_ready) && (|elig);

  always_comb begin
    ack_interface2user = '0;
    ack_interface2user[gnt] = grant;
  end

  always_comb begin
    state_nxt = (state == IDLE) ? (ap_start ? RUN : IDLE) :
                (state == RUN)  ? (ap_start ? RUN : DRAIN) :
                ap_start ? RUN : (out_vld ? DRAIN : IDLE);
  end

  always_comb begin
    for (int i = 0; i < NUM_OUT_PORTS; i++)
      sum[i] = int'(credit[i]) + ((credit_upd && int'(credit_port) == i) ? FREESPACE_UPDATE_SIZE : 0)
               - ((grant && int'(gnt) == i) ? 1 : 0);
  end

  always_ff @(posedge clk_400) begin
    if (reset_400) begin
      state <= IDLE;
      rr <= '0;
      out_vld <= 1'b0;
      out_pkt <= '0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        credit[i] <= CW'(CMAX);
        addr[i] <= '0;
        dst_leaf[i] <= '0;
        dst_port[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      for (int i = 0; i < NUM_OUT_PORTS; i++)
        credit[i] <= (sum[i] > CMAX) ? CW'(CMAX) : CW'(sum[i]);
      if (grant) begin
        rr <= PW'((int'(gnt) + 1) % NUM_OUT_PORTS);
        addr[gnt] <= addr[gnt] + 1'b1;
        out_vld <= 1'b1;
        out_pkt <= PACKET_BITS'({1'b1, dst_leaf[gnt], dst_port[gnt], addr[gnt],
                   din_leaf_user2interface[int'(gnt)*PAYLOAD_BITS +: PAYLOAD_BITS]});
      end else if (bft_ready) begin
        out_vld <= 1'b0;
        out_pkt <= '0;
      end
      if (cfg_we) begin
        dst_leaf[cfg_port] <= cfg_leaf;
        dst_port[cfg_port] <= cfg_dport;
      end
    end
  end

  assign dout_leaf_interface2bft = out_pkt;
endmodule

// File: tb/tb_leaf_out_arbiter.sv
// tb_leaf_out_arbiter: directed stimulus with a packet scoreboard drained by a negedge monitor
module tb_leaf_out_arbiter;
  logic clk_400 = 1'b0;
  logic reset_400, ap_start, cfg_we, credit_upd, bft_ready;
  logic [127:0] din;
  logic [3:0] vld, ack;
  logic [1:0] cfg_port, credit_port;
  logic [4:0] cfg_leaf;
  logic [3:0] cfg_dport;
  logic [48:0] dout;
  logic [48:0] q [$];
  int checks = 0;
  int passed = 0;

  always #5 clk_400 = ~clk_400;

  leaf_out_arbiter dut (
    .clk_400(clk_400), .reset_400(reset_400), .ap_start(ap_start),
    .din_leaf_user2interface(din), .vld_user2interface(vld), .ack_interface2user(ack),
    .cfg_we(cfg_we), .cfg_port(cfg_port), .cfg_leaf(cfg_leaf), .cfg_dport(cfg_dport),
    .credit_upd(credit_upd), .credit_port(credit_port),
    .dout_leaf_interface2bft(dout), .bft_ready(bft_ready)
  );

  function automatic logic [48:0] pkt(logic [4:0] leaf, logic [3:0] dp, logic [6:0] a, logic [31:0] p);
    return {1'b1, leaf, dp, a, p};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_ack(string name);
    bit seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk_400);
      seen = (ack != 4'b0);
    end
    checks++;
    if (seen) passed++;
    else $display("FAIL %s: ack stayed 0, expected a grant within 10 cycles", name);
  endtask

  task automatic tick();
    @(posedge clk_400);
    #1;
  endtask

  task automatic do_reset();
    repeat (3) @(negedge clk_400);
    chk("drain", 64'(q.size()), 0);
    tick();
    reset_400 = 1'b1;
    ap_start = 1'b0;
    vld = 4'b0;
    credit_upd = 1'b0;
    cfg_we = 1'b0;
    bft_ready = 1'b1;
    tick();
    @(negedge clk_400);
    chk("rst_dout", 64'(dout), 0);
    chk("rst_ack", 64'(ack), 0);
    tick();
    reset_400 = 1'b0;
  endtask

  always @(negedge clk_400) begin
    if (!reset_400 && dout[48] && bft_ready) begin
      checks++;
      if (q.size() == 0) $display("FAIL sb_unexpected: got %0h expected no packet", dout);
      else begin
        logic [48:0] e;
        e = q.pop_front();
        if (dout === e) passed++;
        else $display("FAIL sb_pkt: got %0h expected %0h", dout, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    reset_400 = 1'b1;
    ap_start = 1'b0;
    vld = 4'b0;
    cfg_we = 1'b0;
    cfg_port = 2'd0;
    cfg_leaf = 5'd0;
    cfg_dport = 4'd0;
    credit_upd = 1'b0;
    credit_port = 2'd0;
    bft_ready = 1'b1;
    din = '0;
    for (int i = 0; i < 4; i++) din[i*32 +: 32] = 32'hA000_0000 | i;

    // rotation across all four ports
    do_reset();
    ap_start = 1'b1;
    vld = 4'hF;
    wait_ack("rot_first");
    for (int n = 0; n < 8; n++) begin
      if (n > 0) @(negedge clk_400);
      chk($sformatf("rot_ack%0d", n), 64'(ack), 64'(4'b1 << (n % 4)));
      if (n > 0) chk($sformatf("rot_vld%0d", n), 64'(dout[48]), 1);
      q.push_back(pkt(5'd0, 4'd0, 7'(n / 4), 32'hA000_0000 | (n % 4)));
    end
    tick();
    vld = 4'b0;

    // credit exhaustion on port 2, then one refill
    do_reset();
    ap_start = 1'b1;
    vld = 4'b0100;
    din[64 +: 32] = 32'h2222_0000;
    cnt = 0;
    repeat (140) begin
      @(negedge clk_400);
      if (ack[2]) begin
        q.push_back(pkt(5'd0, 4'd0, 7'(cnt), 32'h2222_0000));
        cnt++;
      end
    end
    chk("credit_exhaust", 64'(cnt), 128);
    chk("ack_after_exhaust", 64'(ack), 0);
    tick();
    credit_upd = 1'b1;
    credit_port = 2'd2;
    tick();
    credit_upd = 1'b0;
    repeat (80) begin
      @(negedge clk_400);
      if (ack[2]) begin
        q.push_back(pkt(5'd0, 4'd0, 7'(cnt), 32'h2222_0000));
        cnt++;
      end
    end
    chk("credit_refill", 64'(cnt), 192);
    tick();
    vld = 4'b0;

    // grant and update same cycle at credit 100 saturates at 128
    do_reset();
    ap_start = 1'b1;
    vld = 4'b0100;
    cnt = 0;
    for (int i = 0; i < 60 && cnt < 28; i++) begin
      @(negedge clk_400);
      if (ack[2]) begin
        q.push_back(pkt(5'd0, 4'd0, 7'(cnt), 32'h2222_0000));
        cnt++;
      end
    end
    tick();
    credit_upd = 1'b1;
    credit_port = 2'd2;
    @(negedge clk_400);
    chk("upd_grant", 64'(ack), 64'(4'b0100));
    if (ack[2]) begin
      q.push_back(pkt(5'd0, 4'd0, 7'(cnt), 32'h2222_0000));
      cnt++;
    end
    tick();
    credit_upd = 1'b0;
    repeat (200) begin
      @(negedge clk_400);
      if (ack[2]) begin
        q.push_back(pkt(5'd0, 4'd0, 7'(cnt), 32'h2222_0000));
        cnt++;
      end
    end
    chk("sat_total", 64'(cnt), 157);
    tick();
    vld = 4'b0;

    // destination table write, incl. same-cycle write using old entry
    do_reset();
    cfg_we = 1'b1;
    cfg_port = 2'd1;
    cfg_leaf = 5'd5;
    cfg_dport = 4'd3;
    tick();
    cfg_we = 1'b0;
    ap_start = 1'b1;
    vld = 4'b0010;
    din[32 +: 32] = 32'hDEAD_BEEF;
    wait_ack("cfg_first");
    chk("cfg_ack0", 64'(ack), 64'(4'b0010));
    q.push_back(pkt(5'd5, 4'd3, 7'd0, 32'hDEAD_BEEF));
    tick();
    cfg_we = 1'b1;
    cfg_leaf = 5'd9;
    cfg_dport = 4'd7;
    @(negedge clk_400);
    chk("cfg_leaf", 64'(dout[47:43]), 5);
    chk("cfg_dport", 64'(dout[42:39]), 3);
    chk("cfg_valid", 64'(dout[48]), 1);
    chk("cfg_payload", 64'(dout[31:0]), 64'h DEAD_BEEF);
    chk("cfg_ack1", 64'(ack), 64'(4'b0010));
    q.push_back(pkt(5'd5, 4'd3, 7'd1, 32'hDEAD_BEEF));
    tick();
    cfg_we = 1'b0;
    @(negedge clk_400);
    chk("cfg_ack2", 64'(ack), 64'(4'b0010));
    q.push_back(pkt(5'd9, 4'd7, 7'd2, 32'hDEAD_BEEF));
    tick();
    vld = 4'b0;

    // backpressure holds dout and blocks grants
    do_reset();
    ap_start = 1'b1;
    vld = 4'b0001;
    din[0 +: 32] = 32'h1111_1111;
    wait_ack("bp_first");
    q.push_back(pkt(5'd0, 4'd0, 7'd0, 32'h1111_1111));
    tick();
    bft_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_400);
      chk($sformatf("bp_ack%0d", i), 64'(ack), 0);
      chk($sformatf("bp_hold%0d", i), 64'(dout), 64'(pkt(5'd0, 4'd0, 7'd0, 32'h1111_1111)));
    end
    tick();
    bft_ready = 1'b1;
    @(negedge clk_400);
    chk("bp_refill", 64'(ack), 64'(4'b0001));
    q.push_back(pkt(5'd0, 4'd0, 7'd1, 32'h1111_1111));
    tick();
    vld = 4'b0;
    @(negedge clk_400);
    chk("bp_next", 64'(dout), 64'(pkt(5'd0, 4'd0, 7'd1, 32'h1111_1111)));

    // ap_start drop keeps the pending packet until accepted
    do_reset();
    ap_start = 1'b1;
    vld = 4'b0001;
    wait_ack("drain_first");
    q.push_back(pkt(5'd0, 4'd0, 7'd0, 32'h1111_1111));
    tick();
    ap_start = 1'b0;
    bft_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_400);
      chk($sformatf("drain_ack%0d", i), 64'(ack), 0);
      chk($sformatf("drain_hold%0d", i), 64'(dout), 64'(pkt(5'd0, 4'd0, 7'd0, 32'h1111_1111)));
    end
    tick();
    bft_ready = 1'b1;
    @(negedge clk_400);
    chk("drain_accept_ack", 64'(ack), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_400);
      chk($sformatf("idle_dout%0d", i), 64'(dout), 0);
      chk($sformatf("idle_ack%0d", i), 64'(ack), 0);
    end
    tick();
    vld = 4'b0;

    // reset mid-operation discards pending packet without further acks
    do_reset();
    ap_start = 1'b1;
    vld = 4'hF;
    wait_ack("mid_first");
    tick();
    reset_400 = 1'b1;
    @(negedge clk_400);
    chk("mid_rst_ack", 64'(ack), 0);
    tick();
    @(negedge clk_400);
    chk("mid_rst_dout", 64'(dout), 0);
    q.delete();
    vld = 4'b0;
    ap_start = 1'b0;
    tick();
    reset_400 = 1'b0;

    repeat (3) @(negedge clk_400);
    chk("final_drain", 64'(q.size()), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
